// File: rtl/fetch_line_buffer.sv
// Two-entry direct-mapped instruction line buffer.
// Serves 32-bit fetch reads from 256-bit lines.
module fetch_line_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ufp_addr,
  input  logic [3:0]   ufp_rmask,
  output logic [31:0]  ufp_rdata,
  output logic         ufp_resp,
  input  logic         inv,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  input  logic [255:0] dfp_rdata,
  input  logic         dfp_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } state_t;

  state_t        state;
  logic [1:0]    valid;
  logic [25:0]   tag_q  [2];
  logic [255:0]  data_q [2];
  logic [31:0]   req_addr;
  logic          inv_seen;

  logic          idx;
  logic [25:0]   tag;
  logic [2:0]    wsel;
  logic          hit;
  logic          fill_done;
  logic          unused;

  assign idx       = ufp_addr[5];
  assign tag       = ufp_addr[31:6];
  assign wsel      = ufp_addr[4:2];
  assign hit       = valid[idx] && (tag_q[idx] == tag);
  assign fill_done = (state == FILL) && dfp_resp;
  assign unused    = ^{ufp_addr[1:0], req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[req_addr[5]]  <= req_addr[31:6];
      data_q[req_addr[5]] <= dfp_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= 2'b00;
      req_addr   <= '0;
      inv_seen   <= 1'b0;
      ufp_rdata  <= '0;
      ufp_resp   <= 1'b0;
      dfp_addr   <= '0;
      dfp_read   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      ufp_resp <= 1'b0;
      if (inv) valid <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|ufp_rmask) begin
            req_addr <= ufp_addr;
            inv_seen <= 1'b0;
            if (hit) begin
              ufp_rdata <= data_q[idx][{wsel, 5'd0} +: 32];
              ufp_resp  <= 1'b1;
              hit_count <= hit_count + 32'd1;
              state     <= RESP;
            end else begin
              dfp_addr   <= {ufp_addr[31:5], 5'd0};
              dfp_read   <= 1'b1;
              miss_count <= miss_count + 32'd1;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (inv) inv_seen <= 1'b1;
          if (dfp_resp) begin
            // an invalidate seen during the fill leaves the line unusable
            valid[req_addr[5]] <= !(inv || inv_seen);
            ufp_rdata <= dfp_rdata[{req_addr[4:2], 5'd0} +: 32];
            ufp_resp  <= 1'b1;
            dfp_read  <= 1'b0;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer.
// Vector table plus reset and throughput sequences.
module tb_fetch_line_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic         inv;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  fetch_line_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .ufp_addr  (ufp_addr),
    .ufp_rmask (ufp_rmask),
    .ufp_rdata (ufp_rdata),
    .ufp_resp  (ufp_resp),
    .inv       (inv),
    .dfp_addr  (dfp_addr),
    .dfp_read  (dfp_read),
    .dfp_rdata (dfp_rdata),
    .dfp_resp  (dfp_resp),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    int          dly;
    logic [31:0] base;
    int          inv_at;
    bit          inv_acc;
    bit          exp_miss;
    logic [31:0] exp_rdata;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + i;
    return l;
  endfunction

  function automatic void add(input logic [31:0] a, input int d,
                              input logic [31:0] b, input int ia,
                              input bit iq, input bit m,
                              input logic [31:0] rd,
                              input logic [31:0] h,
                              input logic [31:0] ms);
    vec_t v;
    v.addr = a; v.dly = d; v.base = b;
    v.inv_at = ia; v.inv_acc = iq;
    v.exp_miss = m; v.exp_rdata = rd;
    v.exp_hits = h; v.exp_misses = ms;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    logic [31:0] da;
    logic [31:0] exp_da;
    bit          miss;
    int          lat;
    int          cnt;
    da = '0; miss = 0; cnt = 0;
    @(negedge clk);
    ufp_addr  = v.addr;
    ufp_rmask = 4'hF;
    inv       = v.inv_acc;
    @(negedge clk);
    inv = 1'b0;
    lat = 1;
    while (!ufp_resp && lat < 64) begin
      if (dfp_read) begin
        if (!miss) begin
          miss = 1;
          da   = dfp_addr;
        end
        inv = (cnt == v.inv_at);
        if (cnt == v.dly) begin
          dfp_resp  = 1'b1;
          dfp_rdata = mk_line(v.base);
        end
        cnt++;
      end
      @(negedge clk);
      dfp_resp = 1'b0;
      inv      = 1'b0;
      lat++;
    end
    chk($sformatf("v%0d resp", n), {31'd0, ufp_resp}, 32'd1);
    chk($sformatf("v%0d rdata", n), ufp_rdata, v.exp_rdata);
    chk($sformatf("v%0d missflag", n), {31'd0, miss},
        {31'd0, v.exp_miss});
    chk($sformatf("v%0d latency", n), lat,
        v.exp_miss ? v.dly + 2 : 1);
    chk($sformatf("v%0d read_in_resp", n), {31'd0, dfp_read}, 32'd0);
    chk($sformatf("v%0d hits", n), hit_count, v.exp_hits);
    chk($sformatf("v%0d misses", n), miss_count, v.exp_misses);
    if (v.exp_miss) begin
      exp_da = {v.addr[31:5], 5'd0};
      chk($sformatf("v%0d dfp_addr", n), da, exp_da);
    end
    ufp_rmask = 4'h0;
    @(negedge clk);
    chk($sformatf("v%0d pulse_end", n), {31'd0, ufp_resp}, 32'd0);
  endtask

  initial begin
    logic exp_resp;
    rst       = 1'b1;
    ufp_addr  = '0;
    ufp_rmask = 4'h0;
    inv       = 1'b0;
    dfp_rdata = '0;
    dfp_resp  = 1'b0;

    //   addr          dly base   ia iq m  rdata          hits misses
    add(32'h1000_0000, 3, 32'hA0, -1, 0, 1, 32'hA0, 32'd0, 32'd1);
    add(32'h1000_001C, 0, 32'h00, -1, 0, 0, 32'hA7, 32'd1, 32'd1);
    add(32'h1000_0020, 0, 32'hB0, -1, 0, 1, 32'hB0, 32'd1, 32'd2);
    add(32'h1000_0004, 0, 32'h00, -1, 0, 0, 32'hA1, 32'd2, 32'd2);
    add(32'h1000_0024, 0, 32'h00, -1, 0, 0, 32'hB1, 32'd3, 32'd2);
    add(32'h2000_0000, 1, 32'hC0, -1, 0, 1, 32'hC0, 32'd3, 32'd3);
    add(32'h1000_0000, 2, 32'hA0, -1, 0, 1, 32'hA0, 32'd3, 32'd4);
    add(32'h2000_0008, 0, 32'hC0, -1, 0, 1, 32'hC2, 32'd3, 32'd5);
    add(32'h1000_003C, 0, 32'h00, -1, 0, 0, 32'hB7, 32'd4, 32'd5);
    add(32'h1000_0027, 0, 32'h00, -1, 0, 0, 32'hB1, 32'd5, 32'd5);
    add(32'h3000_0008, 3, 32'hD0,  1, 0, 1, 32'hD2, 32'd5, 32'd6);
    add(32'h3000_0008, 0, 32'hD0, -1, 0, 1, 32'hD2, 32'd5, 32'd7);
    add(32'h3000_0008, 0, 32'h00, -1, 0, 0, 32'hD2, 32'd6, 32'd7);
    add(32'h1000_0020, 1, 32'hE0, -1, 0, 1, 32'hE0, 32'd6, 32'd8);
    add(32'h1000_0024, 0, 32'h00, -1, 1, 0, 32'hE1, 32'd7, 32'd8);
    add(32'h1000_0024, 0, 32'hF0, -1, 0, 1, 32'hF1, 32'd7, 32'd9);
    add(32'h3000_0008, 0, 32'hD0, -1, 0, 1, 32'hD2, 32'd7, 32'd10);

    repeat (2) @(negedge clk);
    chk("rst resp", {31'd0, ufp_resp}, 32'd0);
    chk("rst rdata", ufp_rdata, 32'd0);
    chk("rst dfp_read", {31'd0, dfp_read}, 32'd0);
    chk("rst dfp_addr", dfp_addr, 32'd0);
    chk("rst hits", hit_count, 32'd0);
    chk("rst misses", miss_count, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // back-to-back hits: one response every two cycles
    @(negedge clk);
    ufp_addr  = 32'h3000_0008;
    ufp_rmask = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_resp = (i % 2 == 0);
      chk($sformatf("tput resp%0d", i), {31'd0, ufp_resp},
          {31'd0, exp_resp});
    end
    ufp_rmask = 4'h0;
    chk("tput hits", hit_count, 32'd10);
    chk("tput rdata", ufp_rdata, 32'hD2);

    // reset in the middle of a fill
    @(negedge clk);
    ufp_addr  = 32'h4000_0000;
    ufp_rmask = 4'hF;
    @(negedge clk);
    chk("mid read", {31'd0, dfp_read}, 32'd1);
    chk("mid misses", miss_count, 32'd11);
    rst = 1'b1;
    #1;
    chk("arst read", {31'd0, dfp_read}, 32'd0);
    chk("arst addr", dfp_addr, 32'd0);
    chk("arst rdata", ufp_rdata, 32'd0);
    chk("arst hits", hit_count, 32'd0);
    chk("arst misses", miss_count, 32'd0);
    ufp_rmask = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    dfp_resp  = 1'b1;
    dfp_rdata = mk_line(32'h77);
    @(negedge clk);
    dfp_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stale resp%0d", i), {31'd0, ufp_resp}, 32'd0);
      chk($sformatf("stale read%0d", i), {31'd0, dfp_read}, 32'd0);
      @(negedge clk);
    end
    chk("stale hits", hit_count, 32'd0);
    chk("stale misses", miss_count, 32'd0);
    chk("stale rdata", ufp_rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
